// File: rtl/fp_adder_rs_pkg.sv
// Shared constants for the FP add/subtract reservation station: opcodes,
// instruction field positions and tag/data widths.
package fp_adder_rs_pkg;

    localparam int DATA_W = 16;
    localparam int TAG_W  = 3;

    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;

    localparam logic [TAG_W-1:0] NO_TAG = '0;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RD_MSB = 11;
    localparam int RD_LSB = 9;
    localparam int RS_MSB = 8;
    localparam int RS_LSB = 6;
    localparam int RT_MSB = 5;
    localparam int RT_LSB = 3;

    function automatic logic isValidOp(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/fp_adder_rs_add_unit.sv
// Non-pipelined adder: the result is computed at start and released on the
// done pulse exactly LATENCY cycles later; result holds between pulses.
module fp_add_unit
    import fp_adder_rs_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              idle,
    output logic              finish,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    logic              running;
    logic [7:0]        count;
    logic [DATA_W-1:0] sum;

    assign idle   = !running;
    assign finish = running && (count == '0);

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            running <= 1'b0;
            count   <= '0;
            sum     <= '0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            if (finish) begin
                running <= 1'b0;
                done    <= 1'b1;
                result  <= sum;
            end else if (running) begin
                count <= count - 8'd1;
            end else if (start) begin
                running <= 1'b1;
                count   <= 8'(LATENCY - 1);
                sum     <= (op == OP_SUB) ? (a - b) : (a + b);
            end
        end
    end

endmodule

// File: rtl/fp_adder_rs.sv
// Reservation station for the FP add/sub unit: captures operands or producer
// tags at issue, snoops the CDB, and feeds ready entries to fp_add_unit.
module fp_adder_rs
    import fp_adder_rs_pkg::*;
#(
    parameter int NUM_RS      = 2,
    parameter int TAG_BASE    = 1,
    parameter int ADD_LATENCY = 2
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic [15:0]       instruction,
    input  logic              Adderin,
    input  logic [2:0]        qj_in,
    input  logic [2:0]        qk_in,
    input  logic [15:0]       R1,
    input  logic [15:0]       R2,
    input  logic [15:0]       R3,
    input  logic [15:0]       R4,
    input  logic [15:0]       R5,
    input  logic [15:0]       R6,
    input  logic [15:0]       R7,
    input  logic              cdb_valid,
    input  logic [2:0]        cdb_tag,
    input  logic [15:0]       cdb_data,
    output logic              Busy,
    output logic [2:0]        issue_tag,
    output logic              instOutEnable,
    output logic [15:0]       instOut,
    output logic              done,
    output logic [15:0]       dout,
    output logic [2:0]        doutAddress,
    output logic [2:0]        done_tag
);

    logic [NUM_RS-1:0] entBusy;
    logic [NUM_RS-1:0] entExec;
    logic [TAG_W-1:0]  entQj   [NUM_RS];
    logic [TAG_W-1:0]  entQk   [NUM_RS];
    logic [DATA_W-1:0] entVj   [NUM_RS];
    logic [DATA_W-1:0] entVk   [NUM_RS];
    logic [DATA_W-1:0] entInst [NUM_RS];

    logic [DATA_W-1:0] regVal [8];
    logic [2:0]        freeIdx, readyIdx, execIdx;
    logic              freeFound, readyFound;
    logic [DATA_W-1:0] dispInst, dispVj, dispVk;
    logic [TAG_W-1:0]  newQj, newQk;
    logic [DATA_W-1:0] newVj, newVk;
    logic              accept, dispatch, unitIdle, unitFinish;

    always_comb begin
        regVal[0] = '0;
        regVal[1] = R1;
        regVal[2] = R2;
        regVal[3] = R3;
        regVal[4] = R4;
        regVal[5] = R5;
        regVal[6] = R6;
        regVal[7] = R7;
    end

    // Scanning from the top down leaves the lowest-index match selected.
    always_comb begin
        freeFound  = 1'b0;
        freeIdx    = '0;
        readyFound = 1'b0;
        readyIdx   = '0;
        dispInst   = '0;
        dispVj     = '0;
        dispVk     = '0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (!entBusy[i]) begin
                freeFound = 1'b1;
                freeIdx   = 3'(i);
            end
            if (entBusy[i] && !entExec[i] && entQj[i] == NO_TAG && entQk[i] == NO_TAG) begin
                readyFound = 1'b1;
                readyIdx   = 3'(i);
                dispInst   = entInst[i];
                dispVj     = entVj[i];
                dispVk     = entVk[i];
            end
        end
    end

    // A same-cycle CDB broadcast of the producer tag is taken as the value.
    always_comb begin
        newQj = qj_in;
        newVj = '0;
        if (qj_in == NO_TAG) begin
            newVj = regVal[instruction[RS_MSB:RS_LSB]];
        end else if (cdb_valid && cdb_tag == qj_in) begin
            newQj = NO_TAG;
            newVj = cdb_data;
        end
        newQk = qk_in;
        newVk = '0;
        if (qk_in == NO_TAG) begin
            newVk = regVal[instruction[RT_MSB:RT_LSB]];
        end else if (cdb_valid && cdb_tag == qk_in) begin
            newQk = NO_TAG;
            newVk = cdb_data;
        end
    end

    assign Busy      = !freeFound;
    assign issue_tag = 3'(TAG_BASE) + freeIdx;
    assign accept    = Adderin && !Busy && isValidOp(instruction[OP_MSB:OP_LSB]);
    assign dispatch  = readyFound && unitIdle;

    fp_add_unit #(.LATENCY(ADD_LATENCY)) addUnit (
        .clock  (clock),
        .Reset  (Reset),
        .start  (dispatch),
        .op     (dispInst[OP_MSB:OP_LSB]),
        .a      (dispVj),
        .b      (dispVk),
        .idle   (unitIdle),
        .finish (unitFinish),
        .done   (done),
        .result (dout)
    );

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            entBusy       <= '0;
            entExec       <= '0;
            for (int i = 0; i < NUM_RS; i++) begin
                entQj[i]   <= NO_TAG;
                entQk[i]   <= NO_TAG;
                entVj[i]   <= '0;
                entVk[i]   <= '0;
                entInst[i] <= '0;
            end
            instOutEnable <= 1'b0;
            instOut       <= '0;
            doutAddress   <= '0;
            done_tag      <= '0;
            execIdx       <= '0;
        end else begin
            instOutEnable <= dispatch;
            if (dispatch) begin
                instOut <= dispInst;
                execIdx <= readyIdx;
            end
            for (int i = 0; i < NUM_RS; i++) begin
                if (unitFinish && execIdx == 3'(i)) begin
                    entBusy[i]  <= 1'b0;
                    entExec[i]  <= 1'b0;
                    doutAddress <= entInst[i][RD_MSB:RD_LSB];
                    done_tag    <= 3'(TAG_BASE + i);
                end
                if (dispatch && readyIdx == 3'(i)) begin
                    entExec[i] <= 1'b1;
                end
                // Issue only targets a free entry, snoop only busy ones.
                if (accept && freeIdx == 3'(i)) begin
                    entBusy[i] <= 1'b1;
                    entExec[i] <= 1'b0;
                    entInst[i] <= instruction;
                    entQj[i]   <= newQj;
                    entVj[i]   <= newVj;
                    entQk[i]   <= newQk;
                    entVk[i]   <= newVk;
                end else if (cdb_valid && entBusy[i]) begin
                    if (entQj[i] != NO_TAG && entQj[i] == cdb_tag) begin
                        entQj[i] <= NO_TAG;
                        entVj[i] <= cdb_data;
                    end
                    if (entQk[i] != NO_TAG && entQk[i] == cdb_tag) begin
                        entQk[i] <= NO_TAG;
                        entVk[i] <= cdb_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_adder_rs.sv
// Scoreboard bench for fp_adder_rs: expected results are pushed at issue time
// and matched by tag when the station reports done.
module tb_fp_adder_rs;
    import fp_adder_rs_pkg::*;

    localparam int NUM_RS   = 2;
    localparam int TAG_BASE = 1;
    localparam int LAT      = 2;

    logic        clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] instruction = '0;
    logic        Adderin = 1'b0;
    logic [2:0]  qj_in = '0;
    logic [2:0]  qk_in = '0;
    logic [15:0] regs [8];
    logic        cdb_valid = 1'b0;
    logic [2:0]  cdb_tag = '0;
    logic [15:0] cdb_data = '0;
    logic        Busy;
    logic [2:0]  issue_tag;
    logic        instOutEnable;
    logic [15:0] instOut;
    logic        done;
    logic [15:0] dout;
    logic [2:0]  doutAddress;
    logic [2:0]  done_tag;

    typedef struct packed {
        logic [2:0]  tag;
        logic [2:0]  rd;
        logic [15:0] value;
    } expT;

    expT expQ[$];
    bit  occ [NUM_RS];
    int  testsRun = 0;
    int  testsFailed = 0;
    int  cycle = 0;
    int  dispCycle = 0;
    int  doneCount = 0;
    int  doneTags[$];
    int  dispCycles[$];

    always #5 clock = ~clock;

    fp_adder_rs #(.NUM_RS(NUM_RS), .TAG_BASE(TAG_BASE), .ADD_LATENCY(LAT)) dut (
        .clock(clock), .Reset(Reset), .instruction(instruction), .Adderin(Adderin),
        .qj_in(qj_in), .qk_in(qk_in),
        .R1(regs[1]), .R2(regs[2]), .R3(regs[3]), .R4(regs[4]),
        .R5(regs[5]), .R6(regs[6]), .R7(regs[7]),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .Busy(Busy), .issue_tag(issue_tag), .instOutEnable(instOutEnable),
        .instOut(instOut), .done(done), .dout(dout),
        .doutAddress(doutAddress), .done_tag(done_tag)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    always @(posedge clock) cycle = cycle + 1;

    // Monitor: matches each done pulse against the scoreboard by tag.
    always @(negedge clock) begin : monitor
        int idx;
        if (!Reset) begin
            if (done) begin
                doneCount++;
                doneTags.push_back(int'(done_tag));
                checkOutput("doneLatency", cycle - dispCycle, LAT);
                idx = -1;
                foreach (expQ[i]) if (idx < 0 && expQ[i].tag == done_tag) idx = i;
                if (idx < 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpectedDone: actual tag=%0d dout=%0h, required no result", done_tag, dout);
                end else begin
                    checkOutput("dout", dout, expQ[idx].value);
                    checkOutput("doutAddress", doutAddress, expQ[idx].rd);
                    occ[expQ[idx].tag - TAG_BASE] = 1'b0;
                    expQ.delete(idx);
                end
            end
            if (instOutEnable) begin
                dispCycle = cycle;
                dispCycles.push_back(cycle);
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                                 input logic [2:0] rt, input logic [2:0] qj, input logic [2:0] qk,
                                 input logic [15:0] pj, input logic [15:0] pk, input bit bypassJ);
        logic [15:0] a, b;
        int  tag;
        int  waitCount;
        expT e;
        waitCount = 0;
        @(posedge clock); #1;
        while (Busy && waitCount < 50) begin
            @(posedge clock); #1;
            waitCount++;
        end
        if (Busy) begin
            checkOutput("issueWaitBusy", Busy, 0);
            return;
        end
        instruction = {op, rd, rs, rt, 3'b000};
        qj_in = qj;
        qk_in = qk;
        Adderin = 1'b1;
        if (bypassJ) begin
            cdb_valid = 1'b1;
            cdb_tag = qj;
            cdb_data = pj;
        end
        @(negedge clock); #1;
        if (isValidOp(op)) begin
            tag = -1;
            for (int i = NUM_RS - 1; i >= 0; i--) if (!occ[i]) tag = i;
            if (tag < 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL issueModel: actual Busy=%0d, required Busy=1 with all tags outstanding", Busy);
            end else begin
                checkOutput("issueTag", issue_tag, TAG_BASE + tag);
                occ[tag] = 1'b1;
                a = (qj == 3'd0) ? regs[rs] : pj;
                b = (qk == 3'd0) ? regs[rt] : pk;
                e.tag = 3'(TAG_BASE + tag);
                e.rd = rd;
                e.value = (op == OP_ADD) ? (a + b) : (a - b);
                expQ.push_back(e);
            end
        end
        @(posedge clock); #1;
        Adderin = 1'b0;
        cdb_valid = 1'b0;
    endtask

    task automatic broadcast(input logic [2:0] tag, input logic [15:0] data);
        cdb_valid = 1'b1;
        cdb_tag = tag;
        cdb_data = data;
        @(posedge clock); #1;
        cdb_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() > 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        if (expQ.size() > 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL drainTimeout: actual pending=%0d, required 0", expQ.size());
            expQ.delete();
        end
        @(posedge clock); #1;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rstBusy", Busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstInstOutEnable", instOutEnable, 0);
        checkOutput("rstDout", dout, 0);
        checkOutput("rstDoutAddress", doutAddress, 0);
        checkOutput("rstDoneTag", done_tag, 0);
        checkOutput("rstInstOut", instOut, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, savedDone, d;
        logic [3:0] op;
        logic [2:0] rd, rs, rt, qj, qk;
        logic [15:0] pj, pk;
        bit byp;
        for (int i = 0; i < 8; i++) regs[i] = '0;
        for (int i = 0; i < NUM_RS; i++) occ[i] = 1'b0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        checkResetOutputs();
        #1 Reset = 1'b0;

        // Basic ADD with ready operands and dispatch timing.
        regs[2] = 16'd5;
        regs[3] = 16'd7;
        applyStimulus(OP_ADD, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0, 16'd0, 16'd0, 1'b0);
        @(negedge clock);
        checkOutput("noEarlyDispatch", instOutEnable, 0);
        @(negedge clock);
        checkOutput("dispatchStrobe", instOutEnable, 1);
        checkOutput("instOut", instOut, {OP_ADD, 3'd1, 3'd2, 3'd3, 3'd0});
        waitDrain();

        // SUB going negative and ADD wrapping to zero.
        regs[4] = 16'd3;
        regs[5] = 16'd5;
        regs[6] = 16'hFFFF;
        regs[7] = 16'd1;
        applyStimulus(OP_SUB, 3'd2, 3'd4, 3'd5, 3'd0, 3'd0, 16'd0, 16'd0, 1'b0);
        applyStimulus(OP_ADD, 3'd3, 3'd6, 3'd7, 3'd0, 3'd0, 16'd0, 16'd0, 1'b0);
        waitDrain();

        // Operand arriving later on the CDB.
        regs[5] = 16'd4;
        applyStimulus(OP_ADD, 3'd4, 3'd1, 3'd5, 3'd3, 3'd0, 16'd10, 16'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("pendingHold", instOutEnable, 0);
        end
        @(posedge clock); #1;
        broadcast(3'd3, 16'd10);
        @(negedge clock);
        checkOutput("snoopNotYet", instOutEnable, 0);
        @(negedge clock);
        checkOutput("snoopDispatch", instOutEnable, 1);
        waitDrain();

        // Same-cycle CDB bypass at issue.
        applyStimulus(OP_ADD, 3'd5, 3'd0, 3'd5, 3'd3, 3'd0, 16'd10, 16'd0, 1'b1);
        @(negedge clock);
        checkOutput("bypassNotYet", instOutEnable, 0);
        @(negedge clock);
        checkOutput("bypassDispatch", instOutEnable, 1);
        waitDrain();

        // Fill both entries, ignored third issue, reuse after done.
        applyStimulus(OP_ADD, 3'd1, 3'd2, 3'd3, 3'd3, 3'd0, 16'd20, 16'd0, 1'b0);
        applyStimulus(OP_SUB, 3'd2, 3'd0, 3'd4, 3'd4, 3'd0, 16'd9, 16'd0, 1'b0);
        @(negedge clock);
        checkOutput("busyFull", Busy, 1);
        @(posedge clock); #1;
        instruction = {OP_ADD, 3'd7, 3'd2, 3'd3, 3'b000};
        qj_in = 3'd0;
        qk_in = 3'd0;
        Adderin = 1'b1;
        @(posedge clock); #1;
        Adderin = 1'b0;
        broadcast(3'd3, 16'd20);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!done && n < 20);
        checkOutput("firstDoneSeen", done, 1);
        @(negedge clock);
        checkOutput("busyAfterDone", Busy, 0);
        applyStimulus(OP_ADD, 3'd6, 3'd2, 3'd3, 3'd0, 3'd0, 16'd0, 16'd0, 1'b0);
        broadcast(3'd4, 16'd9);
        waitDrain();

        // Two entries becoming ready together: lower index goes first.
        doneTags.delete();
        dispCycles.delete();
        applyStimulus(OP_ADD, 3'd1, 3'd2, 3'd3, 3'd5, 3'd0, 16'd100, 16'd0, 1'b0);
        applyStimulus(OP_SUB, 3'd2, 3'd2, 3'd3, 3'd5, 3'd0, 16'd100, 16'd0, 1'b0);
        broadcast(3'd5, 16'd100);
        waitDrain();
        checkOutput("orderDoneCount", doneTags.size(), 2);
        checkOutput("orderFirstTag", doneTags[0], 1);
        checkOutput("orderSecondTag", doneTags[1], 2);
        checkOutput("orderDispatchGap", dispCycles[1] - dispCycles[0], LAT + 1);

        // Reset in the middle of execution.
        applyStimulus(OP_ADD, 3'd3, 3'd2, 3'd3, 3'd0, 3'd0, 16'd0, 16'd0, 1'b0);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!instOutEnable && n < 20);
        checkOutput("preResetDispatch", instOutEnable, 1);
        @(posedge clock); #1;
        Reset = 1'b1;
        #1;
        checkResetOutputs();
        expQ.delete();
        for (int i = 0; i < NUM_RS; i++) occ[i] = 1'b0;
        savedDone = doneCount;
        repeat (2) @(posedge clock);
        #1 Reset = 1'b0;
        repeat (LAT + 4) @(posedge clock);
        checkOutput("noDoneAfterReset", doneCount - savedDone, 0);
        #1;

        // Randomized traffic against the reference model.
        for (int it = 0; it < 40; it++) begin
            for (int r = 1; r < 8; r++) regs[r] = 16'($urandom);
            d = $urandom_range(0, 9);
            op = (d == 0) ? 4'($urandom_range(3, 15)) : ((d < 5) ? OP_ADD : OP_SUB);
            rd = 3'($urandom_range(0, 7));
            rs = 3'($urandom_range(0, 7));
            rt = 3'($urandom_range(0, 7));
            qj = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(3, 4)) : 3'd0;
            qk = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(5, 7)) : 3'd0;
            pj = 16'($urandom);
            pk = 16'($urandom);
            byp = (qj != 3'd0) && ($urandom_range(0, 1) == 1);
            applyStimulus(op, rd, rs, rt, qj, qk, pj, pk, byp);
            if (qj != 3'd0 && !byp) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clock); #1;
                end
                broadcast(qj, pj);
            end
            if (qk != 3'd0) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clock); #1;
                end
                broadcast(qk, pk);
            end
        end
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/fp_adder_rs.md
Name:
fp_adder_rs

Overview:
Reservation-station block for the FP add/subtract functional unit of the Tomasulo core. It accepts issued ADD/SUB instructions and captures operands either from the register file outputs R1..R7 or as producer tags. It snoops the common data bus for pending operands, dispatches ready entries to an internal multi-cycle adder, and broadcasts each result with its destination register and station tag. It sits between the instruction queue/issue logic and the CDB arbiter.

Parameters:
NUM_RS, 2, number of reservation-station entries (1..6).
TAG_BASE, 1, tag of entry 0; entry i has tag TAG_BASE+i; tag 0 means "value ready".
ADD_LATENCY, 2, cycles from dispatch to result (minimum 1).

Ports:
clock  in  1  rising-edge clock
Reset  in  1  asynchronous active-high reset
instruction  in  16  issued instruction: [15:12] op, [11:9] rd, [8:6] rs, [5:3] rt, [2:0] unused
Adderin  in  1  issue strobe; accepted when Busy=0 and op is valid
qj_in  in  3  producer tag of rs from the register status table; 0 means ready
qk_in  in  3  producer tag of rt; 0 means ready
R1..R7  in  16 each  architectural register values; register index 0 reads as 0
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  3  CDB producer tag
cdb_data  in  16  CDB value
Busy  out  1  all entries occupied (combinational from registered state)
issue_tag  out  3  tag allocated to the accepted instruction; valid while Adderin and Busy=0
instOutEnable  out  1  one-cycle pulse when an entry dispatches to the adder
instOut  out  16  instruction word of the dispatched entry
done  out  1  one-cycle result-valid pulse
dout  out  16  result
doutAddress  out  3  destination register (rd) of the result
done_tag  out  3  tag of the completing entry

Behaviour:
- Opcodes: ADD=4'h1 gives a+b; SUB=4'h2 gives a-b. Arithmetic is 16-bit two's complement with wrap and no flags. Any other op is not accepted and leaves state unchanged.
- Issue: on the clock edge with Adderin=1, Busy=0 and a valid op, the lowest-index free entry is allocated.
  - The entry stores op, rd, the full instruction, and sets busy.
  - For operand j: if qj_in=0, Vj is taken from the register selected by rs (0 reads as 0) and Qj=0.
  - Otherwise, if cdb_valid and cdb_tag=qj_in in the same cycle, Vj=cdb_data and Qj=0 (bypass).
  - Otherwise Qj=qj_in. Operand k is handled identically.
- Snoop: every cycle with cdb_valid, each busy entry with Qj=cdb_tag (nonzero) loads Vj=cdb_data and clears Qj; same for k.
- Ready: busy, Qj=0, Qk=0, not yet dispatched. An operand captured by snoop in cycle N makes the entry eligible in cycle N+1.
- Dispatch: the adder is non-pipelined. When it is idle, the lowest-index ready entry dispatches; instOutEnable=1 and instOut=that instruction for exactly one cycle; the entry is marked executing.
- Completion: exactly ADD_LATENCY cycles after the dispatch edge, done=1 for one cycle with dout, doutAddress=rd and done_tag.
  - The entry's busy bit clears on that edge and the adder becomes idle.
  - A new dispatch may occur in the cycle after done.
- Busy is computed from registered busy bits. A freed entry can be reallocated no earlier than the cycle after done.
- Adderin while Busy=1 is ignored; the instruction is not latched and no error is raised.
- Reset (async, any time, including mid-execution) clears:
  - all busy, executing, Qj and Qk state;
  - the adder state;
  - the outputs done=0, instOutEnable=0, dout=0, doutAddress=0, done_tag=0 and instOut=0.
  - Busy=0 after reset.
- Outputs dout, doutAddress, done_tag and instOut hold their last values when their strobes are low.

Decomposition:
- Shared package holds: opcode constants (OP_ADD, OP_SUB), instruction field positions, tag width (3), data width (16), and the NO_TAG=0 constant.
- One natural sub-module is fp_add_unit: the non-pipelined ADD_LATENCY-cycle adder with start/op/a/b inputs and done/result outputs.
- Entry storage and select logic stay in the top.

Test Plan:
- Reset, then R2=5, R3=7, issue ADD rd=1 rs=2 rt=3 with qj=qk=0 -> instOutEnable next cycle; done ADD_LATENCY cycles later with dout=12, doutAddress=1, done_tag=1.
- SUB with R4=3, R5=5 -> dout=16'hFFFE. ADD with 16'hFFFF+1 -> dout=0 (wrap).
- Issue ADD with qj_in=3 -> no dispatch. Later cdb_valid, tag=3, data=10 with Vk=4 -> dispatch next cycle, dout=14. Repeat with the CDB match in the issue cycle -> bypass, dispatch next cycle.
- Fill both entries (NUM_RS=2) -> Busy=1; a third Adderin is ignored; after the first done, Busy=0 the next cycle and the third issue succeeds with issue_tag=1.
- Two ready entries -> entry 0 dispatches first; entry 1 dispatches the cycle after entry 0's done; there are two distinct done pulses.
- Assert Reset during execution -> done never pulses, Busy=0, all outputs return to 0 immediately.
